// File: rtl/lc3_fwd_hazard.sv
`default_nettype none
// ============================================================================
// Module   : lc3_fwd_hazard
// Summary  : LC-3 decode-stage operand forwarding and load-use stall logic
//            backed by a shift-register scoreboard of in-flight writers.
// Revision : 1.0 - initial release
// ============================================================================
module lc3_fwd_hazard #(
    parameter int DATA_W = 16,
    parameter int STAGES = 3,
    parameter int CNT_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     adv,
    input  logic                     flush,
    input  logic [15:0]              id_ir,
    input  logic [DATA_W-1:0]        id_a,
    input  logic [DATA_W-1:0]        id_b,
    input  logic [STAGES*DATA_W-1:0] stg_data,
    input  logic [STAGES-1:0]        stg_rdy,
    output logic [DATA_W-1:0]        fwd_a,
    output logic [DATA_W-1:0]        fwd_b,
    output logic                     stall,
    output logic [CNT_W-1:0]         stall_cnt
);

    localparam logic [3:0] c_OP_BR   = 4'b0000;
    localparam logic [3:0] c_OP_ADD  = 4'b0001;
    localparam logic [3:0] c_OP_LD   = 4'b0010;
    localparam logic [3:0] c_OP_ST   = 4'b0011;
    localparam logic [3:0] c_OP_JSR  = 4'b0100;
    localparam logic [3:0] c_OP_AND  = 4'b0101;
    localparam logic [3:0] c_OP_LDR  = 4'b0110;
    localparam logic [3:0] c_OP_STR  = 4'b0111;
    localparam logic [3:0] c_OP_NOT  = 4'b1001;
    localparam logic [3:0] c_OP_LDI  = 4'b1010;
    localparam logic [3:0] c_OP_STI  = 4'b1011;
    localparam logic [3:0] c_OP_JMP  = 4'b1100;
    localparam logic [3:0] c_OP_LEA  = 4'b1110;

    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    // ------------------------------------------------------------------------
    // Instruction decode
    // ------------------------------------------------------------------------
    logic [3:0] w_opcode;
    logic       w_wr;
    logic [2:0] w_dr;
    logic       w_use_a;
    logic       w_use_b;
    logic [2:0] w_src_a;
    logic [2:0] w_src_b;
    logic       w_unused_ir;

    assign w_opcode    = id_ir[15:12];
    assign w_dr        = id_ir[11:9];
    assign w_unused_ir = ^id_ir[4:3];

    always_comb begin
        w_wr    = 1'b0;
        w_use_a = 1'b0;
        w_use_b = 1'b0;
        w_src_a = id_ir[8:6];
        w_src_b = id_ir[2:0];
        case (w_opcode)
            c_OP_ADD, c_OP_AND: begin
                w_wr    = 1'b1;
                w_use_a = 1'b1;
                w_use_b = ~id_ir[5];
            end
            c_OP_NOT, c_OP_LDR: begin
                w_wr    = 1'b1;
                w_use_a = 1'b1;
            end
            c_OP_LD, c_OP_LDI, c_OP_LEA: begin
                w_wr    = 1'b1;
            end
            c_OP_JMP: begin
                w_use_a = 1'b1;
            end
            // JSR (bit11=1) has no register source; JSRR reads BaseR
            c_OP_JSR: begin
                w_use_a = ~id_ir[11];
            end
            c_OP_STR: begin
                w_use_a = 1'b1;
                w_use_b = 1'b1;
                w_src_a = id_ir[11:9];
                w_src_b = id_ir[8:6];
            end
            c_OP_ST, c_OP_STI: begin
                w_use_a = 1'b1;
                w_src_a = id_ir[11:9];
            end
            c_OP_BR: begin
                w_use_a = 1'b0;
            end
            default: begin
                w_wr    = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Scoreboard of in-flight writers, entry 0 is the youngest (EX)
    // ------------------------------------------------------------------------
    logic [STAGES-1:0]       r_valid;
    logic [STAGES-1:0][2:0]  r_dr;
    logic [CNT_W-1:0]        r_stall_cnt;

    // Per-entry match vectors for each operand
    logic [STAGES-1:0] w_hit_a;
    logic [STAGES-1:0] w_hit_b;

    generate
        for (genvar gk = 0; gk < STAGES; gk++) begin : g_match
            assign w_hit_a[gk] = w_use_a & r_valid[gk] & (r_dr[gk] == w_src_a);
            assign w_hit_b[gk] = w_use_b & r_valid[gk] & (r_dr[gk] == w_src_b);
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Youngest-match selection; scanning oldest-first lets younger overwrite
    // ------------------------------------------------------------------------
    logic              w_any_a;
    logic              w_rdy_a;
    logic [DATA_W-1:0] w_dat_a;
    logic              w_any_b;
    logic              w_rdy_b;
    logic [DATA_W-1:0] w_dat_b;

    always_comb begin
        w_any_a = 1'b0;
        w_rdy_a = 1'b0;
        w_dat_a = '0;
        w_any_b = 1'b0;
        w_rdy_b = 1'b0;
        w_dat_b = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            if (w_hit_a[k]) begin
                w_any_a = 1'b1;
                w_rdy_a = stg_rdy[k];
                w_dat_a = stg_data[k*DATA_W +: DATA_W];
            end
            if (w_hit_b[k]) begin
                w_any_b = 1'b1;
                w_rdy_b = stg_rdy[k];
                w_dat_b = stg_data[k*DATA_W +: DATA_W];
            end
        end
    end

    logic w_stall_a;
    logic w_stall_b;
    logic w_stall;

    assign w_stall_a = w_any_a & ~w_rdy_a;
    assign w_stall_b = w_any_b & ~w_rdy_b;
    assign w_stall   = w_stall_a | w_stall_b;

    // An unready match falls back to the register file value while stalled
    assign fwd_a     = (w_any_a & w_rdy_a) ? w_dat_a : id_a;
    assign fwd_b     = (w_any_b & w_rdy_b) ? w_dat_b : id_b;
    assign stall     = w_stall;
    assign stall_cnt = r_stall_cnt;

    // ------------------------------------------------------------------------
    // Scoreboard shift register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_dr    <= '0;
        end else if (flush) begin
            r_valid <= '0;
        end else if (adv) begin
            r_valid[0] <= w_wr & ~w_stall;
            r_dr[0]    <= w_dr;
            for (int k = 1; k < STAGES; k++) begin
                r_valid[k] <= r_valid[k-1];
                r_dr[k]    <= r_dr[k-1];
            end
        end
    end

    // Stall counter survives flush; only reset clears it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_stall && adv && (r_stall_cnt != c_CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lc3_fwd_hazard.sv
`default_nettype none
// ============================================================================
// Module   : tb_lc3_fwd_hazard
// Summary  : Scoreboard-based self-checking bench for lc3_fwd_hazard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lc3_fwd_hazard;

    localparam int NS = 3;

    logic        clk;
    logic        rst_n;
    logic        adv;
    logic        flush;
    logic [15:0] id_ir;
    logic [15:0] id_a;
    logic [15:0] id_b;
    logic [47:0] stg_data;
    logic [2:0]  stg_rdy;
    logic [15:0] fwd_a;
    logic [15:0] fwd_b;
    logic        stall;
    logic [7:0]  stall_cnt;

    lc3_fwd_hazard #(
        .DATA_W (16),
        .STAGES (NS),
        .CNT_W  (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .adv       (adv),
        .flush     (flush),
        .id_ir     (id_ir),
        .id_a      (id_a),
        .id_b      (id_b),
        .stg_data  (stg_data),
        .stg_rdy   (stg_rdy),
        .fwd_a     (fwd_a),
        .fwd_b     (fwd_b),
        .stall     (stall),
        .stall_cnt (stall_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        st;
        logic [7:0]  cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    bit       m_valid[NS];
    bit [2:0] m_dr[NS];
    int       m_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NS; k++) begin
            m_valid[k] = 1'b0;
            m_dr[k]    = 3'd0;
        end
        m_cnt = 0;
    endtask

    function automatic void tb_decode(input logic [15:0] ir, output bit wr, output bit [2:0] dr,
                                      output bit ua, output bit [2:0] sa,
                                      output bit ub, output bit [2:0] sb);
        wr = 0; ua = 0; ub = 0;
        dr = ir[11:9]; sa = ir[8:6]; sb = ir[2:0];
        case (ir[15:12])
            4'h1, 4'h5: begin wr = 1; ua = 1; ub = !ir[5]; end
            4'h9, 4'h6: begin wr = 1; ua = 1; end
            4'h2, 4'hA, 4'hE: wr = 1;
            4'hC: ua = 1;
            4'h4: ua = !ir[11];
            4'h7: begin ua = 1; ub = 1; sa = ir[11:9]; sb = ir[8:6]; end
            4'h3, 4'hB: begin ua = 1; sa = ir[11:9]; end
            default: ;
        endcase
    endfunction

    function automatic void resolve(input bit u, input bit [2:0] s, input logic [15:0] rf,
                                    input logic [47:0] d, input logic [2:0] r,
                                    output logic [15:0] v, output bit st);
        v  = rf;
        st = 0;
        if (u) begin
            for (int k = 0; k < NS; k++) begin
                if (m_valid[k] && m_dr[k] == s) begin
                    if (r[k]) v = d[k*16 +: 16];
                    else      st = 1;
                    break;
                end
            end
        end
    endfunction

    // Drive one cycle of stimulus and queue the model's prediction
    task automatic drive(input logic [15:0] ir, input logic [15:0] a, input logic [15:0] b,
                         input logic [47:0] data, input logic [2:0] rdy,
                         input logic av, input logic fl);
        exp_t e;
        bit wr, ua, ub, sta, stb;
        bit [2:0] dr, sa, sb;
        id_ir = ir; id_a = a; id_b = b; stg_data = data; stg_rdy = rdy;
        adv = av; flush = fl;
        tb_decode(ir, wr, dr, ua, sa, ub, sb);
        resolve(ua, sa, a, data, rdy, e.a, sta);
        resolve(ub, sb, b, data, rdy, e.b, stb);
        e.st  = sta | stb;
        e.cnt = m_cnt[7:0];
        exp_q.push_back(e);
    endtask

    // Compare at the falling edge, then advance the model across the rising edge
    task automatic tick();
        exp_t e;
        bit wr, ua, ub;
        bit [2:0] dr, sa, sb;
        e = '{a: 16'h0, b: 16'h0, st: 1'b0, cnt: 8'h0};
        @(negedge clk);
        check("queue_depth", exp_q.size(), 1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("fwd_a", fwd_a, e.a);
            check("fwd_b", fwd_b, e.b);
            check("stall", stall, e.st);
            check("stall_cnt", stall_cnt, e.cnt);
        end
        tb_decode(id_ir, wr, dr, ua, sa, ub, sb);
        @(posedge clk);
        if (e.st && adv && m_cnt < 255) m_cnt++;
        if (flush) begin
            for (int k = 0; k < NS; k++) m_valid[k] = 1'b0;
        end else if (adv) begin
            for (int k = NS - 1; k > 0; k--) begin
                m_valid[k] = m_valid[k-1];
                m_dr[k]    = m_dr[k-1];
            end
            m_valid[0] = wr && !e.st;
            m_dr[0]    = dr;
        end
        #1;
    endtask

    task automatic spec_chk(input string tag, input logic [15:0] fa, input logic [15:0] fb,
                            input logic fs);
        #1;
        check({tag, "_fwd_a"}, fwd_a, fa);
        check({tag, "_fwd_b"}, fwd_b, fb);
        check({tag, "_stall"}, stall, fs);
    endtask

    initial begin
        rst_n = 1'b0; adv = 1'b0; flush = 1'b0;
        id_ir = 16'h1283; id_a = 16'h0A0A; id_b = 16'h0B0B;
        stg_data = '0; stg_rdy = 3'b111;
        model_reset();

        // Reset state, and no capture while reset is held
        #3;
        check("rst_stall", stall, 0);
        check("rst_fwd_a", fwd_a, 16'h0A0A);
        check("rst_fwd_b", fwd_b, 16'h0B0B);
        check("rst_cnt", stall_cnt, 0);
        adv = 1'b1;
        repeat (2) @(posedge clk);
        id_ir = 16'h1841; stg_data = {32'h0, 16'h0042};
        #2;
        check("rst_nocap_a", fwd_a, 16'h0A0A);
        @(negedge clk);
        rst_n = 1'b1; adv = 1'b0;
        @(posedge clk); #1;
        drive(16'h1841, 16'h0A0A, 16'h0B0B, {32'h0, 16'h0042}, 3'b111, 1'b0, 1'b0);
        spec_chk("post_rst", 16'h0A0A, 16'h0B0B, 1'b0);
        tick();

        // ADD R1 then ADD R4,R1,R1 forwards from entry 0
        drive(16'h1283, 16'h1111, 16'h2222, '0, 3'b000, 1'b1, 1'b0); tick();
        drive(16'h1841, 16'h1111, 16'h2222, {32'h0, 16'h0042}, 3'b001, 1'b0, 1'b0);
        spec_chk("fwd_e0", 16'h0042, 16'h0042, 1'b0);
        tick();

        // Load-use stall, then forward from entry 1 once data returns
        drive(16'h6B80, 16'h1111, 16'h2222, '0, 3'b000, 1'b1, 1'b0); tick();
        drive(16'h7B80, 16'hAAAA, 16'hBBBB, '0, 3'b000, 1'b1, 1'b0);
        spec_chk("ld_use", 16'hAAAA, 16'hBBBB, 1'b1);
        tick();
        drive(16'h7B80, 16'hAAAA, 16'hBBBB, {16'h0, 16'h1234, 16'h0}, 3'b010, 1'b1, 1'b0);
        spec_chk("ld_e1", 16'h1234, 16'hBBBB, 1'b0);
        tick();

        // Two writers of R2: youngest wins, and its unready state stalls
        drive(16'h0000, 16'h0, 16'h0, '0, 3'b000, 1'b0, 1'b1); tick();
        drive(16'h1400, 16'h0, 16'h0, '0, 3'b111, 1'b1, 1'b0); tick();
        drive(16'h1400, 16'h0, 16'h0, '0, 3'b111, 1'b1, 1'b0); tick();
        drive(16'h1682, 16'h5555, 16'h6666, {16'h0003, 16'h0002, 16'h0001}, 3'b011, 1'b0, 1'b0);
        spec_chk("young_win", 16'h0001, 16'h0001, 1'b0);
        tick();
        drive(16'h1682, 16'h5555, 16'h6666, {16'h0003, 16'h0002, 16'h0001}, 3'b010, 1'b0, 1'b0);
        spec_chk("young_stall", 16'h5555, 16'h6666, 1'b1);
        tick();

        // Flush beats adv with three valid entries
        drive(16'h1400, 16'h0, 16'h0, '0, 3'b111, 1'b1, 1'b0); tick();
        drive(16'h1682, 16'h0, 16'h0, {16'h0003, 16'h0002, 16'h0001}, 3'b111, 1'b1, 1'b1); tick();
        drive(16'h1682, 16'h7777, 16'h8888, {16'h0003, 16'h0002, 16'h0001}, 3'b111, 1'b0, 1'b0);
        spec_chk("flush", 16'h7777, 16'h8888, 1'b0);
        tick();

        // Non-source opcodes ignore pending writers; JSRR does read BaseR
        drive(16'h6180, 16'h0, 16'h0, '0, 3'b000, 1'b1, 1'b0); tick();
        drive(16'h6F80, 16'h0, 16'h0, '0, 3'b000, 1'b1, 1'b0); tick();
        drive(16'h0E05, 16'h1357, 16'h2468, '0, 3'b000, 1'b0, 1'b0);
        spec_chk("br", 16'h1357, 16'h2468, 1'b0);
        tick();
        drive(16'hF025, 16'h1357, 16'h2468, '0, 3'b000, 1'b0, 1'b0);
        spec_chk("trap", 16'h1357, 16'h2468, 1'b0);
        tick();
        drive(16'h41C0, 16'h1357, 16'h2468, '0, 3'b000, 1'b0, 1'b0); tick();
        drive(16'h4800, 16'h1357, 16'h2468, '0, 3'b000, 1'b0, 1'b0); tick();

        // Random traffic against the model
        for (int i = 0; i < 300; i++) begin
            drive(16'($urandom), 16'($urandom), 16'($urandom),
                  {16'($urandom), 16'($urandom), 16'($urandom)}, 3'($urandom),
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0));
            tick();
        end

        // 300 stall+adv cycles saturate the counter
        drive(16'h0000, 16'h0, 16'h0, '0, 3'b000, 1'b0, 1'b1); tick();
        for (int i = 0; i < 100; i++) begin
            drive(16'h6B80, 16'h0, 16'h0, '0, 3'b000, 1'b1, 1'b0); tick();
            for (int j = 0; j < 3; j++) begin
                drive(16'h7B80, 16'h0, 16'h0, '0, 3'b000, 1'b1, 1'b0); tick();
            end
        end
        check("cnt_sat", stall_cnt, 8'hFF);

        // Asynchronous reset mid-stall
        drive(16'h6B80, 16'h0, 16'h0, '0, 3'b000, 1'b1, 1'b0); tick();
        id_ir = 16'h7B80; id_a = 16'h3C3C; id_b = 16'h4D4D; adv = 1'b1;
        #1;
        check("pre_rst_stall", stall, 1);
        rst_n = 1'b0;
        #1;
        check("arst_stall", stall, 0);
        check("arst_cnt", stall_cnt, 0);
        check("arst_fwd_a", fwd_a, 16'h3C3C);
        #1;
        rst_n = 1'b1; adv = 1'b0;
        model_reset();
        @(posedge clk); #1;
        drive(16'h7B80, 16'h3C3C, 16'h4D4D, '0, 3'b000, 1'b1, 1'b0);
        spec_chk("after_arst", 16'h3C3C, 16'h4D4D, 1'b0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
